// File: rtl/score_event_encoder_if.sv
// Score-update link between the event encoder and the score display/accumulator.
// The master side is the encoder; the slave side is whoever raises events and
// consumes the update stream.
interface score_event_encoder_if;
    logic              startOfFrame;
    logic [2:0]        hitAlien;
    logic              hitUFO;
    logic              playerHit;
    logic              newGame;
    logic signed [7:0] scoreUpdate;
    logic              resetScore;
    logic              pending;
    logic              overflow;

    modport master (
        input  startOfFrame,
        input  hitAlien,
        input  hitUFO,
        input  playerHit,
        input  newGame,
        output scoreUpdate,
        output resetScore,
        output pending,
        output overflow
    );

    modport slave (
        output startOfFrame,
        output hitAlien,
        output hitUFO,
        output playerHit,
        output newGame,
        input  scoreUpdate,
        input  resetScore,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/score_event_encoder.sv
// Turns gameplay hit pulses into a signed per-cycle score update stream.
// Simultaneous events are buffered in per-source counters and drained one per
// clock by a fixed-priority arbiter; every COMBO_LEN served kills earn a bonus.
module score_event_encoder #(
    parameter int          ALIEN0_PTS     = 10,
    parameter int          ALIEN1_PTS     = 20,
    parameter int          ALIEN2_PTS     = 30,
    parameter int          UFO_PTS        = 100,
    parameter int          PLAYER_HIT_PTS = -50,
    parameter int          COMBO_PTS      = 50,
    parameter int unsigned COMBO_LEN      = 5,
    parameter int unsigned COMBO_WINDOW   = 8,
    parameter int unsigned CNT_W          = 4
) (
    input logic                   clk,
    input logic                   resetN,
    score_event_encoder_if.master sif
);

    // Source index 0 has the highest priority.
    localparam int          NSRC  = 5;
    localparam int unsigned CMB_W = $clog2(COMBO_LEN + 1);
    localparam int unsigned GAP_W = $clog2(COMBO_WINDOW + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CMB_W-1:0] CMB_TOP = CMB_W'(COMBO_LEN);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(COMBO_WINDOW);

    localparam logic signed [7:0] PTS_PH    = 8'(PLAYER_HIT_PTS);
    localparam logic signed [7:0] PTS_UFO   = 8'(UFO_PTS);
    localparam logic signed [7:0] PTS_A2    = 8'(ALIEN2_PTS);
    localparam logic signed [7:0] PTS_A1    = 8'(ALIEN1_PTS);
    localparam logic signed [7:0] PTS_A0    = 8'(ALIEN0_PTS);
    localparam logic signed [7:0] PTS_COMBO = 8'(COMBO_PTS);

    if (ALIEN0_PTS < -128 || ALIEN0_PTS > 127 || ALIEN1_PTS < -128 || ALIEN1_PTS > 127 ||
        ALIEN2_PTS < -128 || ALIEN2_PTS > 127 || UFO_PTS < -128 || UFO_PTS > 127 ||
        PLAYER_HIT_PTS < -128 || PLAYER_HIT_PTS > 127 ||
        COMBO_PTS < -128 || COMBO_PTS > 127) begin : g_pts_range
        $error("score_event_encoder: point parameter outside -128..127");
    end

    if (COMBO_LEN == 0 || COMBO_WINDOW == 0 || CNT_W == 0) begin : g_cfg_range
        $error("score_event_encoder: COMBO_LEN, COMBO_WINDOW and CNT_W must be non-zero");
    end

    typedef enum logic [0:0] {StRun, StClear} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q [NSRC];
    logic [CNT_W-1:0]  cnt_d [NSRC];
    logic [NSRC-1:0]   ev;
    logic [NSRC-1:0]   nz;
    logic [NSRC-1:0]   grant;
    logic              bonus_srv;
    logic              kill_srv;
    logic [CMB_W-1:0]  combo_q;
    logic [CMB_W-1:0]  combo_d;
    logic [CMB_W-1:0]  combo_inc;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_d;
    logic              bonus_q;
    logic              bonus_d;
    logic              ovf_q;
    logic              ovf_d;
    logic signed [7:0] pts;
    logic signed [7:0] score_q;
    logic              rs_q;

    assign ev = {sif.hitAlien[0], sif.hitAlien[1], sif.hitAlien[2], sif.hitUFO, sif.playerHit};

    // Fixed-priority grant over registered counters; the bonus only wins when all are empty.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            nz[i] = (cnt_q[i] != '0);
        end
        grant     = nz & (~nz + NSRC'(1));
        bonus_srv = (nz == '0) && bonus_q;
        kill_srv  = |grant[NSRC-1:1];
    end

    // Points for whichever source is served this cycle.
    always_comb begin
        unique case (grant)
            5'b00001: pts = PTS_PH;
            5'b00010: pts = PTS_UFO;
            5'b00100: pts = PTS_A2;
            5'b01000: pts = PTS_A1;
            5'b10000: pts = PTS_A0;
            default:  pts = bonus_srv ? PTS_COMBO : 8'sd0;
        endcase
    end

    // Next values of the pending counters, combo tracking and sticky overflow.
    always_comb begin
        ovf_d     = ovf_q;
        combo_inc = combo_q + 1'b1;
        combo_d   = combo_q;
        bonus_d   = bonus_q;
        gap_d     = gap_q;
        for (int i = 0; i < NSRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ev[i] && !grant[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!ev[i] && grant[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        if (bonus_srv) begin
            bonus_d = 1'b0;
        end
        if (grant[0]) begin
            combo_d = '0;
        end
        if (kill_srv) begin
            gap_d = '0;
            if (combo_inc == CMB_TOP) begin
                combo_d = '0;
                // A second bonus earned before the first is paid out is lost.
                if (bonus_q) begin
                    ovf_d = 1'b1;
                end else begin
                    bonus_d = 1'b1;
                end
            end else begin
                combo_d = combo_inc;
            end
        end else begin
            if (sif.startOfFrame && gap_q != GAP_MAX) begin
                gap_d = gap_q + 1'b1;
            end
            if (gap_d == GAP_MAX) begin
                combo_d = '0;
            end
        end
    end

    // Run/clear state machine with registered outputs; newGame wins over everything.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StRun;
            score_q <= '0;
            rs_q    <= 1'b0;
            combo_q <= '0;
            gap_q   <= '0;
            bonus_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (sif.newGame) begin
            state_q <= StClear;
            score_q <= '0;
            rs_q    <= 1'b1;
            combo_q <= '0;
            gap_q   <= '0;
            bonus_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StClear: begin
                    // State is already zero; events seen here are discarded.
                    state_q <= StRun;
                    score_q <= '0;
                    rs_q    <= 1'b0;
                end
                StRun: begin
                    score_q <= pts;
                    rs_q    <= 1'b0;
                    combo_q <= combo_d;
                    gap_q   <= gap_d;
                    bonus_q <= bonus_d;
                    ovf_q   <= ovf_d;
                    cnt_q   <= cnt_d;
                end
            endcase
        end
    end

    assign sif.scoreUpdate = score_q;
    assign sif.resetScore  = rs_q;
    assign sif.pending     = (|nz) | bonus_q;
    assign sif.overflow    = ovf_q;

endmodule

// File: tb/tb_score_event_encoder.sv
// Self-checking bench for score_event_encoder: directed table, hand-written
// multi-cycle sequences and random traffic, all checked against a small model.
module tb_score_event_encoder;

    logic clk;
    logic resetN;

    score_event_encoder_if sif ();

    score_event_encoder dut (
        .clk   (clk),
        .resetN(resetN),
        .sif   (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int hist[$];
    int want[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_hist(input string name);
        check({name, ".len"}, hist.size(), want.size());
        for (int i = 0; i < hist.size() && i < want.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), hist[i], want[i]);
        end
    endtask

    function automatic int count_of(input int v);
        int n = 0;
        foreach (hist[i]) if (hist[i] == v) n++;
        return n;
    endfunction

    // ---------------- reference model ----------------
    // Sources: 0 playerHit, 1 UFO, 2 alien2, 3 alien1, 4 alien0, 5 combo bonus.
    int  PTS[6] = '{-50, 100, 30, 20, 10, 50};
    int  m_pend[5];
    int  m_combo;
    int  m_gap;
    bit  m_bonus;
    bit  m_ovf;
    bit  m_clear;
    int  e_su;
    bit  e_rs;

    task automatic model_clear();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_combo = 0;
        m_gap   = 0;
        m_bonus = 0;
        m_ovf   = 0;
    endtask

    function automatic bit model_pending();
        bit p = m_bonus;
        foreach (m_pend[i]) if (m_pend[i] > 0) p = 1;
        return p;
    endfunction

    task automatic model_step(input bit sof, input bit [2:0] ha, input bit ufo, input bit ph,
                              input bit ng);
        bit ev[5];
        int src;
        ev[0] = ph;
        ev[1] = ufo;
        ev[2] = ha[2];
        ev[3] = ha[1];
        ev[4] = ha[0];
        if (ng) begin
            model_clear();
            m_clear = 1;
            e_rs    = 1;
            e_su    = 0;
            return;
        end
        if (m_clear) begin
            m_clear = 0;
            e_rs    = 0;
            e_su    = 0;
            return;
        end
        e_rs = 0;
        src  = -1;
        for (int i = 0; i < 5; i++) if (src < 0 && m_pend[i] > 0) src = i;
        if (src < 0 && m_bonus) src = 5;
        e_su = (src >= 0) ? PTS[src] : 0;
        for (int i = 0; i < 5; i++) begin
            if (ev[i] && src != i) begin
                if (m_pend[i] == 15) m_ovf = 1;
                else m_pend[i]++;
            end else if (!ev[i] && src == i) begin
                m_pend[i]--;
            end
        end
        if (src == 5) m_bonus = 0;
        if (src == 0) m_combo = 0;
        if (src >= 1 && src <= 4) begin
            m_gap = 0;
            m_combo++;
            if (m_combo == 5) begin
                m_combo = 0;
                if (m_bonus) m_ovf = 1;
                else m_bonus = 1;
            end
        end else begin
            if (sof && m_gap < 8) m_gap++;
            if (m_gap == 8) m_combo = 0;
        end
    endtask

    // Apply one cycle of inputs, then compare all outputs against the model.
    task automatic step(input bit sof, input bit [2:0] ha, input bit ufo, input bit ph,
                        input bit ng);
        int su;
        sif.startOfFrame = sof;
        sif.hitAlien     = ha;
        sif.hitUFO       = ufo;
        sif.playerHit    = ph;
        sif.newGame      = ng;
        @(posedge clk);
        #1;
        model_step(sof, ha, ufo, ph, ng);
        su = int'($signed(sif.scoreUpdate));
        check("scoreUpdate", su, e_su);
        check("resetScore", int'(sif.resetScore), int'(e_rs));
        check("pending", int'(sif.pending), int'(model_pending()));
        check("overflow", int'(sif.overflow), int'(m_ovf));
        if (su != 0) hist.push_back(su);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 3'b000, 0, 0, 0);
    endtask

    task automatic kills0(input int n);
        repeat (n) step(0, 3'b001, 0, 0, 0);
    endtask

    task automatic new_game();
        step(0, 3'b000, 0, 0, 1);
        step(0, 3'b000, 0, 0, 0);
        hist.delete();
        want.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit       sof;
        bit [2:0] ha;
        bit       ufo;
        bit       ph;
        bit       ng;
        int       su;
        bit       rs;
        bit       pe;
        bit       ov;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{0, 3'b000, 0, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{0, 3'b100, 0, 0, 0,   0, 0, 1, 0};
        tbl[2]  = '{0, 3'b000, 0, 0, 0,  30, 0, 0, 0};
        tbl[3]  = '{0, 3'b000, 0, 0, 0,   0, 0, 0, 0};
        tbl[4]  = '{0, 3'b111, 1, 1, 0,   0, 0, 1, 0};
        tbl[5]  = '{0, 3'b000, 0, 0, 0, -50, 0, 1, 0};
        tbl[6]  = '{0, 3'b000, 0, 0, 0, 100, 0, 1, 0};
        tbl[7]  = '{0, 3'b000, 0, 0, 0,  30, 0, 1, 0};
        tbl[8]  = '{0, 3'b000, 0, 0, 0,  20, 0, 1, 0};
        tbl[9]  = '{0, 3'b000, 0, 0, 0,  10, 0, 0, 0};
        tbl[10] = '{0, 3'b000, 0, 0, 0,   0, 0, 0, 0};
        tbl[11] = '{0, 3'b000, 0, 0, 1,   0, 1, 0, 0};
        tbl[12] = '{0, 3'b000, 0, 0, 0,   0, 0, 0, 0};

        sif.startOfFrame = 0;
        sif.hitAlien     = 3'b000;
        sif.hitUFO       = 0;
        sif.playerHit    = 0;
        sif.newGame      = 0;
        resetN           = 0;
        m_clear          = 0;
        model_clear();
        #12;
        check("reset.scoreUpdate", int'($signed(sif.scoreUpdate)), 0);
        check("reset.resetScore", int'(sif.resetScore), 0);
        check("reset.pending", int'(sif.pending), 0);
        check("reset.overflow", int'(sif.overflow), 0);
        resetN = 1;

        foreach (tbl[i]) begin
            step(tbl[i].sof, tbl[i].ha, tbl[i].ufo, tbl[i].ph, tbl[i].ng);
            check($sformatf("tbl[%0d].scoreUpdate", i), int'($signed(sif.scoreUpdate)), tbl[i].su);
            check($sformatf("tbl[%0d].resetScore", i), int'(sif.resetScore), int'(tbl[i].rs));
            check($sformatf("tbl[%0d].pending", i), int'(sif.pending), int'(tbl[i].pe));
            check($sformatf("tbl[%0d].overflow", i), int'(sif.overflow), int'(tbl[i].ov));
        end

        // Five served kills earn one bonus right after the fifth.
        new_game();
        kills0(5);
        idle(10);
        want = '{10, 10, 10, 10, 10, 50};
        check_hist("combo5");

        // A served playerHit restarts the combo.
        new_game();
        kills0(4);
        idle(6);
        step(0, 3'b000, 0, 1, 0);
        idle(4);
        kills0(4);
        idle(6);
        want = '{10, 10, 10, 10, -50, 10, 10, 10, 10};
        check_hist("combo_ph");
        kills0(1);
        idle(6);
        want = '{10, 10, 10, 10, -50, 10, 10, 10, 10, 10, 50};
        check_hist("combo_ph_bonus");

        // Eight quiet frames clear a partial combo.
        new_game();
        kills0(4);
        idle(6);
        repeat (8) begin
            step(1, 3'b000, 0, 0, 0);
            idle(1);
        end
        kills0(1);
        idle(6);
        check("window.bonus_after_gap", count_of(50), 0);
        kills0(3);
        idle(6);
        check("window.bonus_early", count_of(50), 0);
        kills0(1);
        idle(6);
        want = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 50};
        check_hist("window");

        // alien1 saturates while playerHit keeps the arbiter busy.
        new_game();
        repeat (16) step(0, 3'b010, 0, 1, 0);
        check("sat.overflow_set", int'(sif.overflow), 1);
        idle(60);
        check("sat.alien1_updates", count_of(20), 15);
        check("sat.player_updates", count_of(-50), 16);
        check("sat.overflow_sticky", int'(sif.overflow), 1);
        check("sat.pending_drained", int'(sif.pending), 0);

        // newGame with events pending: no stale points afterwards.
        hist.delete();
        step(0, 3'b111, 0, 0, 0);
        step(0, 3'b000, 0, 0, 1);
        check("ng.resetScore", int'(sif.resetScore), 1);
        check("ng.scoreUpdate", int'($signed(sif.scoreUpdate)), 0);
        idle(1);
        check("ng.after_resetScore", int'(sif.resetScore), 0);
        check("ng.after_pending", int'(sif.pending), 0);
        check("ng.after_overflow", int'(sif.overflow), 0);
        idle(5);
        check("ng.stale_points", hist.size(), 0);

        // Held newGame keeps resetScore high; events in the clear cycle are ignored.
        step(0, 3'b000, 0, 0, 1);
        step(0, 3'b111, 1, 1, 1);
        check("ng_hold.resetScore", int'(sif.resetScore), 1);
        step(0, 3'b111, 1, 1, 0);
        idle(3);
        check("ng_hold.ignored", int'(sif.pending), 0);

        // Asynchronous reset in the middle of a drain.
        step(0, 3'b111, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        #3;
        resetN = 0;
        #1;
        check("areset.scoreUpdate", int'($signed(sif.scoreUpdate)), 0);
        check("areset.pending", int'(sif.pending), 0);
        check("areset.overflow", int'(sif.overflow), 0);
        #2;
        resetN = 1;
        model_clear();
        m_clear = 0;
        hist.delete();
        idle(4);
        check("areset.no_points", hist.size(), 0);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            bit [2:0] ha;
            ha[0] = ($urandom_range(5) == 0);
            ha[1] = ($urandom_range(5) == 0);
            ha[2] = ($urandom_range(5) == 0);
            step(($urandom_range(7) == 0), ha, ($urandom_range(9) == 0),
                 ($urandom_range(11) == 0), ($urandom_range(149) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
